// File: rtl/cordic_cart_to_polar_pkg.sv
// Shared types and constants for the CORDIC Cartesian-to-polar engine.
//   state_e      : FSM state encoding (idle / rotate / done)
//   GainShift/Sub: shift-add terms approximating 1/K (K = CORDIC gain, ~1.6468)
//   atan_lut()   : round(atan(2^-i) * 2^ang_w / (2*pi)), valid for ang_w <= 31
package cordic_pkg;

  typedef enum logic [1:0] {StIdle, StRotate, StDone} state_e;

  // r = (x>>1) + (x>>3) - (x>>6) - (x>>9) ~= 0.6074 * x
  localparam int unsigned GainTerms = 4;
  localparam int unsigned GainShift [GainTerms] = '{1, 3, 6, 9};
  localparam bit          GainSub   [GainTerms] = '{1'b0, 1'b0, 1'b1, 1'b1};

  // Angles held as fractions of a full turn scaled by 2^32, then rounded down to ang_w bits.
  function automatic logic [31:0] atan_lut(input int unsigned i, input int unsigned ang_w);
    logic [63:0] base;
    logic [63:0] rounded;
    case (i)
      0:       base = 64'd536870912;
      1:       base = 64'd316933406;
      2:       base = 64'd167458907;
      3:       base = 64'd85004803;
      4:       base = 64'd42667408;
      5:       base = 64'd21354462;
      6:       base = 64'd10679778;
      7:       base = 64'd5340233;
      // Beyond i=7 atan(2^-i) equals 2^-i to well under one part in 2^14.
      default: base = 64'd683565276 >> i;
    endcase
    rounded = (base + (64'd1 << (31 - ang_w))) >> (32 - ang_w);
    return rounded[31:0];
  endfunction

endpackage

// File: rtl/cordic_cart_to_polar_if.sv
// Handshake bundle for cordic_cart_to_polar.
//   input side : in_valid/in_ready, signed x_in/y_in, pass-through z_in
//   output side: out_valid/out_ready, magnitude r_out, angle theta_out, z_out
// slave is the converter, master is the producer/consumer around it.
interface cordic_cart_to_polar_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned Z_W   = 8,
  parameter int unsigned ANG_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [W-1:0]     x_in;
  logic signed [W-1:0]     y_in;
  logic        [Z_W-1:0]   z_in;
  logic                    out_valid;
  logic                    out_ready;
  logic        [W-1:0]     r_out;
  logic        [ANG_W-1:0] theta_out;
  logic        [Z_W-1:0]   z_out;

  modport slave (
    input  in_valid, x_in, y_in, z_in, out_ready,
    output in_ready, out_valid, r_out, theta_out, z_out
  );

  modport master (
    output in_valid, x_in, y_in, z_in, out_ready,
    input  in_ready, out_valid, r_out, theta_out, z_out
  );
endinterface

// File: rtl/cordic_gain_comp.sv
// Combinational CORDIC gain compensation: scales the final x by ~1/1.6468 with a
// fixed shift-add network (each term truncated) and saturates to an unsigned W-bit r.
//   x_i : signed W+2-bit CORDIC x after the last micro-rotation
//   r_o : unsigned magnitude, clamped to [0, 2^W-1]
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic signed [W+1:0] x_i,
  output logic        [W-1:0] r_o
);

  localparam int unsigned AW = W + 3;
  localparam logic signed [AW-1:0] RMax = AW'((1 << W) - 1);

  logic signed [AW-1:0] acc;
  logic signed [W+1:0]  term;

  always_comb begin
    acc  = '0;
    term = '0;
    for (int k = 0; k < GainTerms; k++) begin
      term = x_i >>> GainShift[k];
      if (GainSub[k]) acc = acc - AW'(term);
      else            acc = acc + AW'(term);
    end
    if (acc < 0)         r_o = '0;
    else if (acc > RMax) r_o = '1;
    else                 r_o = acc[W-1:0];
  end

endmodule

// File: rtl/cordic_cart_to_polar.sv
// Iterative CORDIC vectoring engine: signed (x, y) -> (r, theta), z passed through.
// One sample in flight: accept in idle, ITER micro-rotations, then hold the result
// until the consumer takes it.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of cordic_cart_to_polar_if (valid/ready in and out)
module cordic_cart_to_polar
  import cordic_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned Z_W   = 8,
  parameter int unsigned ANG_W = 8,
  parameter int unsigned ITER  = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  cordic_cart_to_polar_if.slave bus
);

  // Two guard bits: pre-rotation of -2^(W-1) plus CORDIC growth (<1.65*sqrt(2)) fit.
  localparam int unsigned DW   = W + 2;
  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [ANG_W-1:0] HalfTurn = {1'b1, {(ANG_W - 1){1'b0}}};

  state_e state_q, state_d;

  logic        [CntW-1:0]  iter_q, iter_d;
  logic signed [DW-1:0]    x_q, x_d, y_q, y_d;
  logic        [ANG_W-1:0] z_q, z_d;
  logic        [ANG_W-1:0] theta_q, theta_d;
  logic        [W-1:0]     r_q, r_d;
  logic        [Z_W-1:0]   zp_q, zp_d;
  logic                    zero_q, zero_d;

  logic        [ANG_W-1:0] atan_tab [ITER];
  logic signed [DW-1:0]    x_ext, y_ext, x_shr, y_shr, x_rot, y_rot;
  logic        [ANG_W-1:0] z_rot;
  logic        [W-1:0]     r_comp;
  logic                    last_iter;

  for (genvar g = 0; g < ITER; g++) begin : gen_atan
    assign atan_tab[g] = ANG_W'(atan_lut(g, ANG_W));
  end

  assign x_ext     = {{2{bus.x_in[W-1]}}, bus.x_in};
  assign y_ext     = {{2{bus.y_in[W-1]}}, bus.y_in};
  assign last_iter = (iter_q == CntW'(ITER - 1));

  // One micro-rotation: drive y toward zero, accumulate the rotated angle in z.
  always_comb begin
    x_shr = x_q >>> iter_q;
    y_shr = y_q >>> iter_q;
    if (!y_q[DW-1]) begin
      x_rot = x_q + y_shr;
      y_rot = y_q - x_shr;
      z_rot = z_q + atan_tab[iter_q];
    end else begin
      x_rot = x_q - y_shr;
      y_rot = y_q + x_shr;
      z_rot = z_q - atan_tab[iter_q];
    end
  end

  cordic_gain_comp #(
    .W (W)
  ) u_gain_comp (
    .x_i (x_rot),
    .r_o (r_comp)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.in_valid)  state_d = StRotate;
      StRotate: if (last_iter)     state_d = StDone;
      StDone:   if (bus.out_ready) state_d = StIdle;
      default:                     state_d = StIdle;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    iter_d  = iter_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zp_d    = zp_q;
    zero_d  = zero_q;
    r_d     = r_q;
    theta_d = theta_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          iter_d = '0;
          zp_d   = bus.z_in;
          zero_d = (bus.x_in == '0) && (bus.y_in == '0);
          // Fold the left half-plane onto the right so the iterations converge.
          if (bus.x_in[W-1]) begin
            x_d = -x_ext;
            y_d = -y_ext;
            z_d = HalfTurn;
          end else begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = '0;
          end
        end
      end
      StRotate: begin
        x_d    = x_rot;
        y_d    = y_rot;
        z_d    = z_rot;
        iter_d = iter_q + 1'b1;
        if (last_iter) begin
          iter_d  = '0;
          r_d     = r_comp;
          // The iterations would leave the sum of all ATAN entries for (0,0).
          theta_d = zero_q ? '0 : z_rot;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iter_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zp_q    <= '0;
      zero_q  <= 1'b0;
      r_q     <= '0;
      theta_q <= '0;
    end else begin
      iter_q  <= iter_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zp_q    <= zp_d;
      zero_q  <= zero_d;
      r_q     <= r_d;
      theta_q <= theta_d;
    end
  end

  // Outputs.
  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.r_out     = r_q;
    bus.theta_out = theta_q;
    bus.z_out     = zp_q;
  end

endmodule

// File: doc/cordic_cart_to_polar.md
Name: cordic_cart_to_polar

Overview:
- Iterative CORDIC vectoring engine. Converts a signed Cartesian pair (x, y) to magnitude r and angle theta, with a z channel passed through, giving full cylindrical coordinates.
- Parametrised successor of the team's 4-bit combinational cylindrical converter. Adds signed four-quadrant inputs, configurable precision, valid/ready handshakes and gain-compensated magnitude.
- Sits between sensor-data ingress and downstream consumers in the tt_um wrapper.

Parameters:
- W, 8: width of signed x, y inputs and unsigned r output.
- Z_W, 8: width of pass-through z.
- ANG_W, 8: theta width; full turn = 2^ANG_W units.
- ITER, 8: CORDIC micro-rotations, 1..W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- x_in  in  W  signed two's-complement x.
- y_in  in  W  signed two's-complement y.
- z_in  in  Z_W  z coordinate, passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- r_out  out  W  unsigned magnitude.
- theta_out  out  ANG_W  angle, 0..2^ANG_W-1 counter-clockwise from +x.
- z_out  out  Z_W  registered copy of z_in.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; out_valid=0; r_out=0; theta_out=0; z_out=0; iteration counter=0.
  - in_ready=1 from the first cycle after rst_n rises.
  - Reset mid-operation aborts the conversion; the partial result is discarded.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, capture the operands, do the pre-rotation, latch z and go to ROTATE.
  - ROTATE: one micro-rotation per cycle, i=0..ITER-1. After i=ITER-1, go to DONE.
  - DONE: out_valid=1 and outputs are registered and held stable. On out_ready, go to IDLE.
- in_ready is 1 only in IDLE. in_valid outside IDLE is ignored and nothing is queued.
- Latency: out_valid rises exactly ITER+1 cycles after the accepting edge. Throughput is one sample per ITER+2 cycles minimum.
- Pre-rotation:
  - If x_in<0: x0=-x_in, y0=-y_in, z0=2^(ANG_W-1).
  - Else: x0=x_in, y0=y_in, z0=0.
- Datapath width:
  - Internal x and y are signed, W+2 bits. Sign-extend on capture; no overflow is possible, including x_in=-2^(W-1).
- Iteration i:
  - If y>=0: x+=y>>>i, y-=x>>>i, z+=ATAN[i].
  - Else: x-=y>>>i, y+=x>>>i, z-=ATAN[i].
  - All updates use old x, y values (simultaneous update). Shifts are arithmetic.
  - z is ANG_W bits and wraps modulo 2^ANG_W.
- ATAN[i] = round(atan(2^-i)*2^ANG_W/(2*pi)). For ANG_W=8: 32, 19, 10, 5, 3, 1, 1, 0.
- Gain compensation on entry to DONE:
  - r = (x>>1)+(x>>3)-(x>>6)-(x>>9), each term truncated.
  - Result is saturated to 2^W-1.
- Zero input: x_in=y_in=0 forces r_out=0 and theta_out=0. The FSM timing is unchanged.
- Accuracy vs ideal:
  - |r error| <= 2 LSB.
  - |theta error| <= 1 LSB, measured modulo 2^ANG_W.

Decomposition:
- Package cordic_pkg holds:
  - state enum {IDLE, ROTATE, DONE};
  - function atan_lut(i, ANG_W) returning ATAN[i];
  - localparam gain-compensation shift set {1, 3, 6, 9} with signs.
- One natural sub-module: cordic_gain_comp, a combinational shift-add and saturate, with parameter W.
- The FSM, counter and datapath stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, outputs 0, no capture. in_ready=1 on the first cycle after release.
- Axis points, W=ANG_W=ITER=8, z_in=5:
  - (100,0) -> r=100±2, theta=0±1 (255 allowed), z_out=5, out_valid exactly 9 cycles after accept.
  - (0,100) -> theta=64±1.
  - (-100,0) -> theta=128±1.
  - (0,-100) -> theta=192±1.
- Extremes:
  - (-128,-128) -> r=181±2, theta=160±1, no overflow.
  - (0,0) -> r=0, theta=0.
- Backpressure: out_ready=0 for 5 cycles in DONE -> r/theta/z stable, in_ready=0, a concurrent in_valid sample is not captured. out_ready=1 -> IDLE next cycle.
- Reset mid-ROTATE: pulse rst_n low at iteration 3 -> out_valid never asserts for the aborted sample. The following sample (0,100) yields theta=64±1.
- Random sweep: 1000 random (x,y) -> bit-exact match to a C model of the same algorithm; accuracy bounds hold against the ideal atan2/hypot.
